// File: rtl/pe_feed_ctrl.sv
// Feed controller between the row pre-data stage and the PE array.
// It frames a run of rows, buffers them in a two-deep skid FIFO and guards each frame with a watchdog.
module pe_feed_ctrl #(
    parameter int unsigned DATA_W  = 208,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic              dout_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_rows,
    input  logic [7:0]        cfg_padding,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              en,
    output logic [7:0]        input_padding,
    output logic [DATA_W-1:0] pe_data,
    output logic              pe_vld,
    input  logic              pe_ready,
    output logic [7:0]        row_cnt,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        rows_q, rows_d;
    logic [7:0]        pad_q, pad_d;
    logic [7:0]        row_cnt_q, row_cnt_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       wdog_q, wdog_d, wdog_inc;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              pop;
    logic              push;

    always_ff @(posedge dout_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            pad_q     <= '0;
            row_cnt_q <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            pad_q     <= pad_d;
            row_cnt_q <= row_cnt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        pad_d     = pad_q;
        row_cnt_d = row_cnt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        head_d    = head_q;
        skid_d    = skid_q;
        wdog_inc  = wdog_q + 16'd1;
        pop       = (cnt_q != 2'd0) && pe_ready;
        push      = (state_q == RUN) && din_vld;

        // head_q is the output register, skid_q the second entry behind it
        if (push && (cnt_q == 2'd2) && !pop) begin
            err_d[0] = 1'b1;
        end else if (push && pop) begin
            if (cnt_q == 2'd2) begin
                head_d = skid_q;
                skid_d = din;
            end else begin
                head_d = din;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                head_d = din;
                cnt_d  = 2'd1;
            end else begin
                skid_d = din;
                cnt_d  = 2'd2;
            end
        end else if (pop) begin
            head_d = skid_q;
            cnt_d  = cnt_q - 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_rows == 8'd0) begin
                        err_d[1] = 1'b1;
                    end else begin
                        rows_d    = cfg_rows;
                        pad_d     = cfg_padding;
                        row_cnt_d = '0;
                        err_d     = '0;
                        cnt_d     = '0;
                        wdog_d    = '0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (din_vld) begin
                    row_cnt_d = row_cnt_q + 8'd1;
                    wdog_d    = '0;
                    if (row_cnt_d == rows_q) begin
                        state_d = DRAIN;
                    end
                end else if (wdog_inc == TIMEOUT) begin
                    err_d[1] = 1'b1;
                    cnt_d    = '0;
                    wdog_d   = '0;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            DRAIN: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything above, including a start or drop in the same cycle
        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            wdog_d    = '0;
            row_cnt_d = row_cnt_q;
            err_d     = err_q;
            rows_d    = rows_q;
            pad_d     = pad_q;
            head_d    = head_q;
            skid_d    = skid_q;
        end
    end

    assign en            = (state_q == RUN);
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign input_padding = pad_q;
    assign pe_data       = head_q;
    assign pe_vld        = (cnt_q != 2'd0);
    assign row_cnt       = row_cnt_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed bench for pe_feed_ctrl: normal frame, backpressure/drop, simultaneous push+pop,
// zero-row start, watchdog timeout, abort and mid-frame reset.
module tb_pe_feed_ctrl;

    localparam int unsigned DATA_W = 208;

    logic              dout_clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [7:0]        cfg_rows;
    logic [7:0]        cfg_padding;
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              en;
    logic [7:0]        input_padding;
    logic [DATA_W-1:0] pe_data;
    logic              pe_vld;
    logic              pe_ready;
    logic [7:0]        row_cnt;
    logic              busy;
    logic              frame_done;
    logic [1:0]        err;

    int nvec = 0;
    int nerr = 0;
    int fd_seen;

    pe_feed_ctrl #(.DATA_W(DATA_W), .TIMEOUT(16'd16)) dut (
        .dout_clk      (dout_clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_rows      (cfg_rows),
        .cfg_padding   (cfg_padding),
        .din           (din),
        .din_vld       (din_vld),
        .en            (en),
        .input_padding (input_padding),
        .pe_data       (pe_data),
        .pe_vld        (pe_vld),
        .pe_ready      (pe_ready),
        .row_cnt       (row_cnt),
        .busy          (busy),
        .frame_done    (frame_done),
        .err           (err)
    );

    always #5 dout_clk = ~dout_clk;

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dout_clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] word(input logic [7:0] b);
        return {26{b}};
    endfunction

    task automatic start_frame(input logic [7:0] rows, input logic [7:0] pad);
        cfg_rows    = rows;
        cfg_padding = pad;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_rows = '0; cfg_padding = '0;
        din = '0; din_vld = 1'b0; pe_ready = 1'b0;
        tick(); tick();
        check_vec("rst_busy", busy, 1'b0);
        check_vec("rst_en", en, 1'b0);
        check_vec("rst_pe_vld", pe_vld, 1'b0);
        check_vec("rst_pe_data", pe_data, '0);
        check_vec("rst_err", err, 2'b00);
        check_vec("rst_row_cnt", row_cnt, 8'd0);
        rst_n = 1'b1;
        tick();

        // Normal 4-row frame with the PE always ready
        pe_ready = 1'b1;
        start_frame(8'd4, 8'h55);
        check_vec("t1_busy", busy, 1'b1);
        check_vec("t1_en", en, 1'b1);
        check_vec("t1_pad", input_padding, 8'h55);
        check_vec("t1_vld0", pe_vld, 1'b0);
        fd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            din     = word(8'hA0 + 8'(i));
            din_vld = 1'b1;
            tick();
            check_vec("t1_beat_vld", pe_vld, 1'b1);
            check_vec("t1_beat_data", pe_data, word(8'hA0 + 8'(i)));
            fd_seen += int'(frame_done);
        end
        din_vld = 1'b0;
        check_vec("t1_en_low", en, 1'b0);
        check_vec("t1_row_cnt", row_cnt, 8'd4);
        tick();
        fd_seen += int'(frame_done);
        check_vec("t1_drained", pe_vld, 1'b0);
        tick();
        fd_seen += int'(frame_done);
        check_vec("t1_done", frame_done, 1'b1);
        tick();
        fd_seen += int'(frame_done);
        check_vec("t1_idle", busy, 1'b0);
        check_vec("t1_fd_once", fd_seen, 1);
        check_vec("t1_err", err, 2'b00);

        // Backpressure: three rows into a two-entry buffer
        pe_ready = 1'b0;
        start_frame(8'd4, 8'h12);
        for (int i = 0; i < 3; i++) begin
            din     = word(8'hB0 + 8'(i));
            din_vld = 1'b1;
            tick();
            check_vec("t2_head_hold", pe_data, word(8'hB0));
        end
        din_vld = 1'b0;
        check_vec("t2_err_ovf", err, 2'b01);
        check_vec("t2_row_cnt", row_cnt, 8'd3);
        tick();
        check_vec("t2_still_a", pe_data, word(8'hB0));
        pe_ready = 1'b1;
        tick();
        check_vec("t2_second_b", pe_data, word(8'hB1));
        check_vec("t2_second_vld", pe_vld, 1'b1);
        tick();
        check_vec("t2_no_third", pe_vld, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_vec("t2_abort_idle", busy, 1'b0);
        check_vec("t2_abort_err", err, 2'b01);

        // Full buffer with simultaneous pop and push
        pe_ready = 1'b0;
        start_frame(8'd5, 8'h33);
        check_vec("t3_err_cleared", err, 2'b00);
        din = word(8'hD0); din_vld = 1'b1; tick();
        din = word(8'hD1); tick();
        check_vec("t3_head_d", pe_data, word(8'hD0));
        pe_ready = 1'b1;
        din = word(8'hD2); tick();
        din_vld = 1'b0;
        check_vec("t3_no_drop", err, 2'b00);
        check_vec("t3_head_e", pe_data, word(8'hD1));
        tick();
        check_vec("t3_head_f", pe_data, word(8'hD2));
        check_vec("t3_vld_f", pe_vld, 1'b1);
        tick();
        check_vec("t3_empty", pe_vld, 1'b0);
        check_vec("t3_row_cnt", row_cnt, 8'd3);
        abort = 1'b1; tick(); abort = 1'b0;

        // Zero-row start is refused
        start_frame(8'd0, 8'h44);
        check_vec("t4_busy", busy, 1'b0);
        check_vec("t4_err", err, 2'b10);
        check_vec("t4_pad_kept", input_padding, 8'h33);

        // Watchdog with TIMEOUT=16 and no rows
        start_frame(8'd4, 8'h66);
        check_vec("t5_err_cleared", err, 2'b00);
        fd_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            fd_seen += int'(frame_done);
        end
        check_vec("t5_busy_15", busy, 1'b1);
        tick();
        fd_seen += int'(frame_done);
        check_vec("t5_idle_16", busy, 1'b0);
        check_vec("t5_err", err, 2'b10);
        check_vec("t5_no_fd", fd_seen, 0);

        // Abort after two of four rows, then reset mid-frame
        pe_ready = 1'b0;
        start_frame(8'd4, 8'h77);
        din = word(8'hE0); din_vld = 1'b1; tick();
        din = word(8'hE1); tick();
        din_vld = 1'b0;
        check_vec("t6_vld_pre", pe_vld, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        check_vec("t6_abort_idle", busy, 1'b0);
        check_vec("t6_abort_vld", pe_vld, 1'b0);
        check_vec("t6_abort_rows", row_cnt, 8'd2);
        check_vec("t6_abort_pad", input_padding, 8'h77);
        cfg_rows = 8'd4; start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        check_vec("t6_abort_wins", busy, 1'b0);
        start_frame(8'd4, 8'h88);
        din = word(8'hF0); din_vld = 1'b1; tick();
        din_vld = 1'b0;
        check_vec("t6_mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_vec("t6_rst_busy", busy, 1'b0);
        check_vec("t6_rst_vld", pe_vld, 1'b0);
        check_vec("t6_rst_data", pe_data, '0);
        check_vec("t6_rst_rows", row_cnt, 8'd0);
        check_vec("t6_rst_pad", input_padding, 8'h00);
        check_vec("t6_rst_en", en, 1'b0);
        check_vec("t6_rst_err", err, 2'b00);
        check_vec("t6_rst_fd", frame_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check_vec("t6_stay_idle", busy, 1'b0);
        check_vec("t6_stay_empty", pe_vld, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pe_feed_ctrl.md
PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 208, width of the parallel row word from the input pre-data module.
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, idle cycles allowed between rows in RUN before abort.
REQ-003 SHALL have port dout_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle frame start request.
REQ-006 SHALL have port abort, input, 1, synchronous frame cancel.
REQ-007 SHALL have port cfg_rows, input, 8, rows per frame, sampled on accepted start.
REQ-008 SHALL have port cfg_padding, input, 8, padding value, sampled on accepted start.
REQ-009 SHALL have port din, input, DATA_W, row word from the pre-data stage.
REQ-010 SHALL have port din_vld, input, 1, din valid, one cycle per row.
REQ-011 SHALL have port en, output, 1, enable to the pre-data stage.
REQ-012 SHALL have port input_padding, output, 8, latched padding to the pre-data stage.
REQ-013 SHALL have port pe_data, output, DATA_W, row word to the PE array.
REQ-014 SHALL have port pe_vld, output, 1, pe_data valid.
REQ-015 SHALL have port pe_ready, input, 1, PE array accepts pe_data when pe_vld and pe_ready are both high.
REQ-016 SHALL have port row_cnt, output, 8, rows received in the current frame.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port frame_done, output, 1, one-cycle pulse on normal frame completion.
REQ-019 SHALL have port err, output, 2, sticky flags: bit0 overflow, bit1 timeout or zero-row start.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-021 SHALL treat start in IDLE with cfg_rows!=0 as accepted: latch cfg_rows and cfg_padding, clear row_cnt, err and the buffer, then go to RUN next cycle.
REQ-022 SHALL, on start in IDLE with cfg_rows==0, stay in IDLE and set err[1].
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive en=1 only in RUN; input_padding holds the latched value until the next accepted start.
REQ-025 SHALL, in RUN, count every din_vld in row_cnt (dropped rows included); din_vld outside RUN is ignored.
REQ-026 SHALL buffer rows in a 2-entry FIFO (output register plus skid entry); pe_data/pe_vld come from the head, and data is held stable while pe_vld=1 and pe_ready=0.
REQ-027 SHALL give latency: din_vld at cycle N with an empty buffer gives pe_vld=1 at N+1.
REQ-028 SHALL accept a push into a full buffer when a pop occurs in the same cycle; otherwise it drops din and sets err[0].
REQ-029 SHALL go from RUN to DRAIN on the cycle row_cnt reaches the latched cfg_rows; en is low from that cycle onward.
REQ-030 SHALL go from DRAIN to DONE when the buffer is empty, and from DONE to IDLE after one cycle; frame_done=1 only in DONE.
REQ-031 SHALL keep a 16-bit watchdog that clears on each din_vld in RUN and counts otherwise; when it reaches TIMEOUT it sets err[1], clears the buffer and goes to IDLE with no frame_done.
REQ-032 SHALL give abort priority over all other events in any state: go to IDLE next cycle, clear the buffer, drop pe_vld, keep row_cnt and err.
REQ-033 SHALL, when abort and start are both high in IDLE, let abort win and not accept start.
REQ-034 SHALL keep row_cnt at 8 bits with no wrap: the maximum is cfg_rows, at most 255.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force state=IDLE, en=0, input_padding=0, pe_vld=0, pe_data=0, row_cnt=0, busy=0, frame_done=0, err=0, buffer empty and watchdog=0.
REQ-036 SHALL, when reset is asserted mid-frame, discard all buffered rows; operation resumes only on a new start after reset release.

Verification
REQ-037 SHALL test: start with cfg_rows=4 and cfg_padding=8'h55, pe_ready=1, 4 din_vld pulses -> 4 pe_vld beats each one cycle after din_vld, row_cnt=4, frame_done pulses once, en low after the 4th row.
REQ-038 SHALL test: pe_ready=0 and 3 back-to-back din_vld -> first 2 rows held in order, 3rd dropped, err=2'b01, row_cnt=3.
REQ-039 SHALL test: full buffer with a simultaneous pop and push -> no drop, err[0]=0, order preserved.
REQ-040 SHALL test: start with cfg_rows=0 -> stays IDLE, busy=0, err=2'b10.
REQ-041 SHALL test: TIMEOUT=16 and no din_vld after start -> IDLE after 16 cycles, err[1]=1, no frame_done.
REQ-042 SHALL test: abort after 2 of 4 rows, then rst_n pulse mid-frame -> IDLE, pe_vld=0 and row_cnt=2 after abort; all outputs at reset values after rst_n.
